// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: register map, FSM states and default 64 MHz timing for the WS2812B driver.
// Pixel width follows WS2812B_RGBW_EN (32 bits when defined, 24 otherwise).
package ws2812b_pkg;
    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_G      = 4'h1;
    localparam logic [3:0] ADDR_R      = 4'h2;
    localparam logic [3:0] ADDR_B      = 4'h3;
    localparam logic [3:0] ADDR_W      = 4'h4;
    localparam logic [3:0] ADDR_CNT_LO = 4'h5;
    localparam logic [3:0] ADDR_CNT_HI = 4'h6;
    localparam logic [3:0] ADDR_CHMASK = 4'h7;
    localparam int DEF_T0H_CYC = 26;
    localparam int DEF_T1H_CYC = 51;
    localparam int DEF_BIT_CYC = 80;
    localparam int DEF_RST_CYC = 3200;
`ifdef WS2812B_RGBW_EN
    localparam int PIX_W = 32;
`else
    localparam int PIX_W = 24;
`endif
    typedef enum logic [1:0] {IDLE, BIT_HIGH, BIT_LOW, LATCH} state_e;
endpackage

// File: rtl/ws2812b_multi_driver_bit_tx.sv
// ws2812b_bit_tx: one WS2812B bit period (high phase then low phase) driven onto the
// masked channel lines; a new bit may start on the last cycle of the current one.
module ws2812b_bit_tx #(
    parameter int NUM_CH  = 2,
    parameter int T0H_CYC = 26,
    parameter int T1H_CYC = 51,
    parameter int BIT_CYC = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              tx_bit,
    input  logic [NUM_CH-1:0] mask,
    output logic              busy,
    output logic              last,
    output logic              fall,
    output logic [NUM_CH-1:0] line
);
    localparam int CW = $clog2(BIT_CYC);
    logic [CW-1:0] cnt_q, cnt_d, hi_len;
    logic bit_q, bit_d, busy_q, busy_d;
    logic [NUM_CH-1:0] mask_q, mask_d, line_q, line_d;

    always_comb begin
        hi_len = bit_q ? CW'(T1H_CYC) : CW'(T0H_CYC);
        last   = busy_q && cnt_q == CW'(BIT_CYC - 1);
        fall   = busy_q && cnt_q == hi_len - CW'(1);
        cnt_d  = cnt_q + CW'(1);
        bit_d  = bit_q;
        busy_d = busy_q;
        mask_d = mask_q;
        line_d = (cnt_d < hi_len) ? mask_q : '0;
        if (start) begin
            cnt_d  = '0;
            bit_d  = tx_bit;
            busy_d = 1'b1;
            mask_d = mask;
            line_d = mask;
        end else if (last || !busy_q) begin
            cnt_d  = '0;
            busy_d = 1'b0;
            line_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            bit_q  <= 1'b0;
            busy_q <= 1'b0;
            mask_q <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
            mask_q <= mask_d;
            line_q <= line_d;
        end
    end

    assign busy = busy_q;
    assign line = line_q;
endmodule

// File: rtl/ws2812b_multi_driver.sv
// ws2812b_multi_driver: register-programmed WS2812B run generator mirrored onto NUM_CH strips.
// Define WS2812B_RGBW_EN for 32-bit RGBW pixels with the W register at 0x4.
module ws2812b_multi_driver
    import ws2812b_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 10,
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC,
    parameter int RST_CYC = DEF_RST_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        address,
    input  logic              data_write,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic [NUM_CH-1:0] led_out
);
    localparam int BW = $clog2(PIX_W);
    localparam int LW = $clog2(RST_CYC);
    state_e state_q, state_d;
    logic [7:0] g_q, g_d, r_q, r_d, b_q, b_d, w_rd, status;
    logic [CNT_W-1:0] count_q, count_d, pix_left_q, pix_left_d;
    logic [NUM_CH-1:0] chmask_q, chmask_d;
    logic fill_q, fill_d, latch_q, latch_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [PIX_W-1:0] colour, pixel;
    logic [15:0] count_ext;
    logic we, go, tx_start, tx_bit, tx_busy, tx_last, tx_fall;
`ifdef WS2812B_RGBW_EN
    logic [7:0] w_q, w_d;
    assign colour = {g_q, r_q, b_q, w_q};
    assign w_rd   = w_q;
`else
    assign colour = {g_q, r_q, b_q};
    assign w_rd   = status;
`endif

    always_comb begin
        we        = data_write && state_q == IDLE;
        go        = we && address == ADDR_CTRL && data_in[0];
        count_ext = 16'(count_q);
        g_d = g_q;
        r_d = r_q;
        b_d = b_q;
        count_d  = count_q;
        chmask_d = chmask_q;
        fill_d   = fill_q;
        latch_d  = latch_q;
`ifdef WS2812B_RGBW_EN
        w_d = w_q;
        if (we && address == ADDR_W) w_d = data_in;
`endif
        if (we && address == ADDR_CTRL) begin
            latch_d = data_in[1];
            fill_d  = data_in[2];
        end
        if (we && address == ADDR_G) g_d = data_in;
        if (we && address == ADDR_R) r_d = data_in;
        if (we && address == ADDR_B) b_d = data_in;
        if (we && address == ADDR_CNT_LO) count_d = CNT_W'({count_ext[15:8], data_in});
        if (we && address == ADDR_CNT_HI) count_d = CNT_W'({data_in, count_ext[7:0]});
        if (we && address == ADDR_CHMASK) chmask_d = data_in[NUM_CH-1:0];
        // fill_d already holds the CTRL value being written in the start cycle
        pixel      = fill_d ? colour : '0;
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        pix_left_d = pix_left_q;
        lat_cnt_d  = lat_cnt_q;
        tx_start   = 1'b0;
        tx_bit     = 1'b0;
        case (state_q)
            IDLE: if (go && !tx_busy) begin
                if (count_q != '0) begin
                    state_d    = BIT_HIGH;
                    bit_idx_d  = BW'(PIX_W - 1);
                    pix_left_d = count_q;
                    tx_start   = 1'b1;
                    tx_bit     = pixel[bit_idx_d];
                end else if (data_in[1]) begin
                    state_d   = LATCH;
                    lat_cnt_d = '0;
                end
            end
            BIT_HIGH, BIT_LOW: if (tx_last) begin
                if (bit_idx_q != '0 || pix_left_q != CNT_W'(1)) begin
                    state_d    = BIT_HIGH;
                    bit_idx_d  = (bit_idx_q != '0) ? bit_idx_q - BW'(1) : BW'(PIX_W - 1);
                    pix_left_d = (bit_idx_q != '0) ? pix_left_q : pix_left_q - CNT_W'(1);
                    tx_start   = 1'b1;
                    tx_bit     = pixel[bit_idx_d];
                end else begin
                    state_d   = latch_q ? LATCH : IDLE;
                    lat_cnt_d = '0;
                end
            end else if (tx_fall) begin
                state_d = BIT_LOW;
            end
            LATCH: begin
                lat_cnt_d = lat_cnt_q + LW'(1);
                if (lat_cnt_q == LW'(RST_CYC - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        status   = {6'b0, state_q == LATCH, state_q == IDLE};
        data_out = address == ADDR_G      ? g_q :
                   address == ADDR_R      ? r_q :
                   address == ADDR_B      ? b_q :
                   address == ADDR_W      ? w_rd :
                   address == ADDR_CNT_LO ? count_ext[7:0] :
                   address == ADDR_CNT_HI ? count_ext[15:8] :
                   address == ADDR_CHMASK ? 8'(chmask_q) : status;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            g_q        <= '0;
            r_q        <= '0;
            b_q        <= '0;
            count_q    <= '0;
            chmask_q   <= NUM_CH'(1);
            fill_q     <= 1'b0;
            latch_q    <= 1'b0;
            bit_idx_q  <= '0;
            pix_left_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            r_q        <= r_d;
            b_q        <= b_d;
            count_q    <= count_d;
            chmask_q   <= chmask_d;
            fill_q     <= fill_d;
            latch_q    <= latch_d;
            bit_idx_q  <= bit_idx_d;
            pix_left_q <= pix_left_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

`ifdef WS2812B_RGBW_EN
    always_ff @(posedge clk) w_q <= !rst_n ? 8'h00 : w_d;
`endif

    ws2812b_bit_tx #(
        .NUM_CH (NUM_CH),
        .T0H_CYC(T0H_CYC),
        .T1H_CYC(T1H_CYC),
        .BIT_CYC(BIT_CYC)
    ) u_bit_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .start (tx_start),
        .tx_bit(tx_bit),
        .mask  (chmask_q),
        .busy  (tx_busy),
        .last  (tx_last),
        .fall  (tx_fall),
        .line  (led_out)
    );
endmodule

// File: tb/tb_ws2812b_multi_driver.sv
// tb_ws2812b_multi_driver: expected bit stream queued per run, decoded back from led_out by a monitor.
module tb_ws2812b_multi_driver;
    import ws2812b_pkg::*;
    localparam int NCH = 2, T0 = 26, T1 = 51, BC = 80, RC = 3200;
    logic clk = 1'b0, rst_n = 1'b0, data_write = 1'b0;
    logic [3:0] address = ADDR_CTRL;
    logic [7:0] data_in = 8'h00, data_out;
    logic [NCH-1:0] led_out;
    always #5 clk = ~clk;

    ws2812b_multi_driver #(.NUM_CH(NCH), .CNT_W(10), .T0H_CYC(T0), .T1H_CYC(T1), .BIT_CYC(BC), .RST_CYC(RC)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_write(data_write),
        .data_in(data_in), .data_out(data_out), .led_out(led_out));

    typedef struct {bit b; logic [NCH-1:0] mask; bit first;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int total = 0, bad = 0, cyc = 0, hi = 0, rise_cyc = 0, prev_rise = 0;
    logic [NCH-1:0] cur = '0;
    bit glitch = 0;
    logic [7:0] m_g = 0, m_r = 0, m_b = 0, m_w = 0;
    int m_count = 0;
    logic [NCH-1:0] m_mask = 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // decode one bit per falling edge: high length, channel pattern, rise-to-rise period
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) hi = 0;
        else if (led_out != '0) begin
            if (hi == 0) begin
                cur = led_out;
                glitch = 0;
                prev_rise = rise_cyc;
                rise_cyc = cyc;
            end else if (led_out != cur) glitch = 1;
            hi++;
        end else if (hi != 0) begin
            chk("bit_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("high_len", hi, e.b ? T1 : T0);
                chk("ch_pattern", int'(cur), int'(e.mask));
                chk("steady_high", int'(glitch), 0);
                if (!e.first) chk("bit_period", rise_cyc - prev_rise, BC);
            end
            hi = 0;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; data_write = 1'b1;
        @(posedge clk); #1;
        data_write = 1'b0; address = ADDR_CTRL;
    endtask

    task automatic setreg(input logic [3:0] a, input logic [7:0] d);
        wr(a, d);
        if (a == ADDR_G) m_g = d;
        if (a == ADDR_R) m_r = d;
        if (a == ADDR_B) m_b = d;
`ifdef WS2812B_RGBW_EN
        if (a == ADDR_W) m_w = d;
`endif
        if (a == ADDR_CNT_LO) m_count = (m_count & 'h300) | int'(d);
        if (a == ADDR_CNT_HI) m_count = (m_count & 'hff) | (int'(d & 8'h03) << 8);
        if (a == ADDR_CHMASK) m_mask = d[NCH-1:0];
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string name);
        address = a;
        @(negedge clk);
        chk(name, int'(data_out), int'(exp));
        address = ADDR_CTRL;
    endtask

    task automatic push_run(input logic [7:0] ctrl);
        logic [31:0] pix;
`ifdef WS2812B_RGBW_EN
        pix = ctrl[2] ? {m_g, m_r, m_b, m_w} : 32'h0;
`else
        pix = ctrl[2] ? {8'h00, m_g, m_r, m_b} : 32'h0;
`endif
        if (ctrl[0])
            for (int p = 0; p < m_count; p++)
                for (int i = PIX_W - 1; i >= 0; i--)
                    exp_q.push_back('{pix[i], m_mask, p == 0 && i == PIX_W - 1});
    endtask

    task automatic run(input logic [7:0] ctrl, input bit poke);
        int busy = 0, lat = 0, exp_busy;
        exp_busy = ctrl[0] ? m_count * PIX_W * BC + (ctrl[1] ? RC : 0) : 0;
        push_run(ctrl);
        wr(ADDR_CTRL, ctrl);
        for (int c = 0; c < (exp_busy == 0 ? 100 : exp_busy + 200); c++) begin
            @(negedge clk);
            if (address == ADDR_CTRL) begin
                if (data_out[0] && exp_busy != 0) break;
                busy += int'(!data_out[0]);
                lat += int'(data_out[1]);
            end else busy++;
            if (poke && busy == 300) begin address = ADDR_G; data_in = 8'h00; data_write = 1'b1; end
            else if (poke && busy == 301) begin address = ADDR_CTRL; data_in = 8'h07; end
            else if (poke && busy == 302) data_write = 1'b0;
        end
        data_write = 1'b0;
        address = ADDR_CTRL;
        chk("ready_low_cycles", busy, exp_busy);
        chk("latching_cycles", lat, (ctrl[0] && ctrl[1]) ? RC : 0);
        chk("bits_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_led_out", int'(led_out), 0);
        rd(ADDR_CTRL, 8'h01, "reset_status");
        rd(ADDR_G, 8'h00, "reset_g");
        rd(ADDR_R, 8'h00, "reset_r");
        rd(ADDR_B, 8'h00, "reset_b");
        rd(ADDR_CNT_LO, 8'h00, "reset_cnt_lo");
        rd(ADDR_CNT_HI, 8'h00, "reset_cnt_hi");
        rd(ADDR_CHMASK, 8'h01, "reset_chmask");
        setreg(ADDR_CNT_HI, 8'hFF);
        rd(ADDR_CNT_HI, 8'h03, "cnt_hi_unused_bits");
        setreg(ADDR_CNT_HI, 8'h00);
        setreg(ADDR_CHMASK, 8'hFF);
        rd(ADDR_CHMASK, 8'h03, "chmask_unused_bits");
        wr(ADDR_W, 8'h77);
`ifdef WS2812B_RGBW_EN
        m_w = 8'h77;
        rd(ADDR_W, 8'h77, "w_reg");
`else
        rd(ADDR_W, 8'h01, "addr4_status");
`endif
        rd(4'hA, 8'h01, "unmapped_status");
        setreg(ADDR_G, 8'hFF); setreg(ADDR_R, 8'h00); setreg(ADDR_B, 8'hAA);
        setreg(ADDR_CNT_LO, 8'h01); setreg(ADDR_CHMASK, 8'h01);
        rd(ADDR_B, 8'hAA, "b_readback");
        run(8'h05, 0);
        setreg(ADDR_CNT_LO, 8'h03);
        run(8'h07, 0);
        setreg(ADDR_CHMASK, 8'h02); setreg(ADDR_CNT_LO, 8'h02);
        run(8'h01, 0);
        setreg(ADDR_CNT_LO, 8'h00);
        run(8'h03, 0);
        run(8'h01, 0);
        setreg(ADDR_CHMASK, 8'h03); setreg(ADDR_CNT_LO, 8'h02); setreg(ADDR_G, 8'h5A);
        run(8'h07, 1);
        rd(ADDR_G, 8'h5A, "g_after_locked_write");
        setreg(ADDR_CHMASK, 8'h03);
        push_run(8'h05);
        wr(ADDR_CTRL, 8'h05);
        repeat (499) @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("abort_led_out", int'(led_out), 0);
        rd(ADDR_CTRL, 8'h01, "abort_status");
        rst_n = 1'b1;
        m_g = 0; m_r = 0; m_b = 0; m_w = 0; m_count = 0; m_mask = 1;
        rd(ADDR_CHMASK, 8'h01, "abort_chmask");
        rd(ADDR_CNT_LO, 8'h00, "abort_count");
        for (int k = 0; k < 4; k++) begin
            setreg(ADDR_G, 8'($urandom)); setreg(ADDR_R, 8'($urandom)); setreg(ADDR_B, 8'($urandom));
`ifdef WS2812B_RGBW_EN
            setreg(ADDR_W, 8'($urandom));
`endif
            setreg(ADDR_CHMASK, 8'($urandom_range(1, 3)));
            setreg(ADDR_CNT_LO, 8'($urandom_range(1, 2)));
            v = {5'b0, 1'($urandom), 1'($urandom), 1'b1};
            run(v, 0);
            rd(ADDR_R, m_r, "rand_r_readback");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ws2812b_multi_driver.md
WS2812B_MULTI_DRIVER -- requirements
Module: ws2812b_multi_driver

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent LED strip outputs (1..6).
REQ-002 SHALL have parameter CNT_W, default 10, width of the pixel-run counter.
REQ-003 SHALL have parameters T0H_CYC=26, T1H_CYC=51, BIT_CYC=80, RST_CYC=3200: clk cycles for '0' high time, '1' high time, bit period and latch low time, at a 64 MHz clk.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 reset; address in 4 register select; data_write in 1 write strobe; data_in in 8 write data; data_out out 8 read data; led_out out NUM_CH strip data lines.
REQ-005 Reset rst_n SHALL be synchronous and active-low; all logic SHALL be clocked on the rising edge of clk.

Function
REQ-006 Register map SHALL be: 0x0 CTRL, 0x1 G, 0x2 R, 0x3 B, 0x4 W (RGBW build only), 0x5 COUNT_LO, 0x6 COUNT_HI (bits CNT_W-9:0 used), 0x7 CHMASK (bits NUM_CH-1:0 used).
REQ-007 CTRL write fields SHALL be: [0] start, [1] latch after run, [2] fill (1=colour, 0=black).
REQ-008 Reads SHALL return G/R/B/W/COUNT/CHMASK registers at their addresses, unused bits 0; CTRL and unmapped addresses SHALL read {6'b0, latching, ready}.
REQ-009 Writes to any register while ready=0 SHALL be ignored, including a second start.
REQ-010 FSM states SHALL be IDLE, BIT_HIGH, BIT_LOW, LATCH.
REQ-011 A start write with COUNT>0 SHALL move IDLE->BIT_HIGH; ready SHALL read 0 from the cycle after the write.
REQ-012 A start write with COUNT=0 SHALL go IDLE->LATCH if latch=1, else remain IDLE with no output activity.
REQ-013 led_out SHALL be registered: first bit's rising edge appears the cycle after the start write.
REQ-014 Each bit SHALL be high for T1H_CYC ('1') or T0H_CYC ('0') cycles, then low for the remainder of BIT_CYC.
REQ-015 Pixel bit order SHALL be G[7]..G[0], R[7]..R[0], B[7]..B[0], then W[7]..W[0] in RGBW builds; pixel value is the colour registers when fill=1, all zeros when fill=0.
REQ-016 Pixels SHALL be sent back-to-back, no gap between bits or pixels; exactly COUNT pixels per run.
REQ-017 After the last bit: latch=1 -> LATCH for RST_CYC cycles with all outputs low, then IDLE; latch=0 -> IDLE directly.
REQ-018 Channels with CHMASK bit=1 SHALL carry the identical waveform simultaneously; masked-off channels SHALL stay 0 throughout.
REQ-019 Colour, COUNT and CHMASK SHALL be snapshot at start; the run is unaffected by later bus activity.
REQ-020 ready SHALL be 1 exactly when state is IDLE; latching SHALL be 1 exactly in LATCH.
REQ-021 Bit/pixel counters SHALL not wrap: run ends when the pixel counter reaches 0.

Reset
REQ-022 On rst_n=0: state IDLE, led_out all 0, ready=1, colour/COUNT=0, CHMASK=1 (channel 0 only), fill=0, latch=0.
REQ-023 Reset asserted mid-run or mid-latch SHALL abort immediately; led_out SHALL be 0 on the cycle after the reset edge.

Configuration
REQ-024 Macro WS2812B_RGBW_EN defined: 32-bit pixels, W register at 0x4 readable/writable, 32 bits per pixel.
REQ-025 Macro WS2812B_RGBW_EN undefined: 24-bit pixels, address 0x4 unmapped (writes ignored, reads status byte).

Structure
REQ-026 Package ws2812b_pkg SHALL hold register address constants, FSM state enum and default timing constants.
REQ-027 Single-bit waveform timing (high/low phase counter) SHALL be a sub-module ws2812b_bit_tx, with bit, start, busy and line ports.

Verification
REQ-028 G=0xFF,R=0x00,B=0xAA, COUNT=1, CHMASK=1, CTRL=0x05 -> 24 bits on led_out[0]: 8x51-cycle highs, 8x26, then 1,0 alternating; ready=0 for exactly 24*80 cycles.
REQ-029 COUNT=3, CTRL=0x07 -> 72 back-to-back bits, then 3200 low cycles with latching=1, then ready=1.
REQ-030 CHMASK=0b10, COUNT=2, CTRL=0x01 -> led_out[1] carries 48 '0' bits (26-cycle highs); led_out[0] constant 0.
REQ-031 COUNT=0, CTRL=0x03 -> no high pulses, 3200-cycle LATCH, ready returns 1; with CTRL=0x01 ready never drops.
REQ-032 Start run, write G=0x00 and start again mid-run -> both ignored, read G unchanged, waveform unchanged.
REQ-033 Assert rst_n=0 at cycle 500 of a run -> led_out=0 next cycle, ready=1, CHMASK reads 0x01 after release.
